pipe_trace_buffer: RTL and testbench

PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

---
 rtl/pipe_trace_pkg.sv | 17 +
 rtl/trace_trig_match.sv | 34 +++
 rtl/pipe_trace_buffer.sv | 126 ++++++++++++
 tb/tb_pipe_trace_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace buffer: FSM encodings and entry layout.
// Entry layout is {cycle stamp, per-channel valid, channel data}.
package pipe_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_READ  = 3'd4
  } trace_state_t;

  function automatic int entry_w(input int cyc_w, input int num_ch, input int ch_w);
    return cyc_w + num_ch + num_ch * ch_w;
  endfunction

endpackage

// File: rtl/trace_trig_match.sv
// Combinational trigger compare: selected channel is qualified and equal to value on masked bits.
// Zero latency; no flow control.
module trace_trig_match #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 16
) (
  input  logic [NUM_CH*CH_W-1:0]     ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [$clog2(NUM_CH)-1:0]  trig_ch,
  input  logic [CH_W-1:0]            trig_value,
  input  logic [CH_W-1:0]            trig_mask,
  output logic                       match
);

  localparam int TW = $clog2(NUM_CH);

  logic [CH_W-1:0] sel_dat;
  logic            sel_vld;

  // Loop-based mux so an out-of-range channel number simply never matches.
  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_ch == TW'(k)) begin
        sel_dat = ch_data[k*CH_W +: CH_W];
        sel_vld = ch_valid[k];
      end
    end
  end

  assign match = sel_vld && (((sel_dat ^ trig_value) & trig_mask) == '0);

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture of pipeline taps with trigger/post-count or fill-until-full modes.
// One entry stored per qualified cycle; readout is valid/ready, data combinational from the array.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 16,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     arm,
  input  logic                                     abort,
  input  logic                                     mode,
  input  logic [NUM_CH*CH_W-1:0]                   ch_data,
  input  logic [NUM_CH-1:0]                        ch_valid,
  input  logic [$clog2(NUM_CH)-1:0]                trig_ch,
  input  logic [CH_W-1:0]                          trig_value,
  input  logic [CH_W-1:0]                          trig_mask,
  input  logic [$clog2(DEPTH):0]                   post_count,
  output logic [2:0]                               state_o,
  output logic                                     triggered,
  output logic [$clog2(DEPTH):0]                   entry_count,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [entry_w(CYC_W, NUM_CH, CH_W)-1:0]  rd_data,
  output logic                                     rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(CYC_W, NUM_CH, CH_W);

  trace_state_t     state, state_nxt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, post_cnt, post_load;
  logic [CW-1:0]    rd_idx;
  logic             match, we, rd_fire;

  trace_trig_match #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_trig (
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .trig_ch    (trig_ch),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .match      (match)
  );

  assign we        = (state == ST_ARMED || state == ST_POST) && (|ch_valid) && !abort;
  assign post_load = (post_count > CW'(DEPTH-1)) ? AW'(DEPTH-1) : post_count[AW-1:0];
  assign rd_valid  = (state == ST_READ);
  assign rd_last   = rd_valid && (rd_idx == entry_count - CW'(1));
  assign rd_fire   = rd_valid && rd_ready;
  assign rd_data   = mem[rd_ptr];
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm) state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (we) begin
            if (mode) begin
              if (entry_count >= CW'(DEPTH-1)) state_nxt = ST_DONE;
            end else if (match) begin
              state_nxt = (post_load == '0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST:  if (we && post_cnt == AW'(1)) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = (entry_count != '0) ? ST_READ : ST_IDLE;
        ST_READ:  if (rd_fire && rd_last) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cyc_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_idx      <= '0;
      entry_count <= '0;
      post_cnt    <= '0;
      triggered   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_cnt + CYC_W'(1);
      if (state == ST_IDLE && arm && !abort) begin
        wr_ptr      <= '0;
        entry_count <= '0;
        triggered   <= 1'b0;
      end
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (entry_count != CW'(DEPTH)) entry_count <= entry_count + CW'(1);
      end
      if (state == ST_ARMED && we && !mode && match) begin
        triggered <= 1'b1;
        post_cnt  <= post_load;
      end
      if (state == ST_POST && we) post_cnt <= post_cnt - AW'(1);
      // Oldest entry: when full the low bits of entry_count are zero, so this lands on wr_ptr.
      if (state == ST_DONE) begin
        rd_ptr <= wr_ptr - entry_count[AW-1:0];
        rd_idx <= '0;
      end
      if (rd_fire && !abort) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_idx <= rd_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we && !reset) mem[wr_ptr] <= {cyc_cnt, ch_valid, ch_data};
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: trigger-compare vector table plus capture/readout sequences.
// An 8-bit stamp lets captures be aligned so the first sample after arm carries stamp 0.
module tb_pipe_trace_buffer;

  localparam int EW = 8 + 4 + 64;

  logic          clock = 1'b0;
  logic          reset, arm, abort, mode;
  logic [63:0]   ch_data;
  logic [3:0]    ch_valid;
  logic [1:0]    trig_ch;
  logic [15:0]   trig_value, trig_mask;
  logic [4:0]    post_count;
  logic [2:0]    state_o;
  logic          triggered;
  logic [4:0]    entry_count;
  logic          rd_valid, rd_ready, rd_last;
  logic [EW-1:0] rd_data;

  logic [7:0]    cyc;
  logic [EW-1:0] exp_e [32];
  int            n_tests = 0;
  int            n_fail  = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] dat;
    logic        vld;
    logic [15:0] val;
    logic [15:0] msk;
    logic        exp_trig;
  } vec_t;
  vec_t vecs [7];

  pipe_trace_buffer #(.NUM_CH(4), .CH_W(16), .DEPTH(16), .CYC_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .arm         (arm),
    .abort       (abort),
    .mode        (mode),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .trig_ch     (trig_ch),
    .trig_value  (trig_value),
    .trig_mask   (trig_mask),
    .post_count  (post_count),
    .state_o     (state_o),
    .triggered   (triggered),
    .entry_count (entry_count),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last)
  );

  always #5 clock = ~clock;

  // Reference cycle counter, mirrors the free-running stamp the design must keep.
  always @(posedge clock) cyc <= reset ? 8'd0 : cyc + 8'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic [3:0] v);
    ch_valid = v;
    for (int k = 0; k < 4; k++) ch_data[k*16 +: 16] = {4'(k), 4'h0, 8'(s)};
  endtask

  task automatic arm_at_zero();
    int w;
    w = 0;
    while (cyc != 8'hFF && w < 300) begin
      tick();
      w++;
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain(input int n, input int stall_idx);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!rd_valid && w < 8) begin
        tick();
        w++;
      end
      check($sformatf("rd_valid[%0d]", i), rd_valid, 1);
      check($sformatf("rd_data[%0d]", i), rd_data, exp_e[i]);
      check($sformatf("rd_last[%0d]", i), rd_last, (i == n - 1));
      if (i == stall_idx) begin
        for (int c = 0; c < 3; c++) begin
          tick();
          check($sformatf("stall_hold[%0d]", c), rd_data, exp_e[i]);
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    check("drain_idle", state_o, 3'd0);
    check("drain_rd_valid_low", rd_valid, 0);
  endtask

  initial begin
    vecs[0] = '{2'd2, 16'h00A5, 1'b1, 16'h00A5, 16'hFFFF, 1'b1};
    vecs[1] = '{2'd2, 16'h00A4, 1'b1, 16'h00A5, 16'hFFFF, 1'b0};
    vecs[2] = '{2'd1, 16'h1234, 1'b1, 16'h0030, 16'h00F0, 1'b1};
    vecs[3] = '{2'd1, 16'h1244, 1'b1, 16'h0030, 16'h00F0, 1'b0};
    vecs[4] = '{2'd3, 16'hBEEF, 1'b0, 16'hBEEF, 16'hFFFF, 1'b0};
    vecs[5] = '{2'd0, 16'h5A5A, 1'b1, 16'h0000, 16'h0000, 1'b1};
    vecs[6] = '{2'd3, 16'h8001, 1'b1, 16'h0001, 16'h8001, 1'b0};

    // Reset overrides active inputs.
    reset = 1'b1; arm = 1'b1; abort = 1'b0; mode = 1'b0;
    ch_data = '1; ch_valid = '1; trig_ch = '0; trig_value = '0; trig_mask = '0;
    post_count = '0; rd_ready = 1'b1;
    repeat (3) tick();
    check("rst_state", state_o, 3'd0);
    check("rst_triggered", triggered, 0);
    check("rst_entry_count", entry_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    reset = 1'b0; arm = 1'b0; ch_valid = '0; ch_data = '0; rd_ready = 1'b0;
    tick();

    // Trigger compare table: one sample per capture, then abort back to idle.
    for (int i = 0; i < 7; i++) begin
      trig_ch = vecs[i].ch; trig_value = vecs[i].val; trig_mask = vecs[i].msk;
      mode = 1'b0; post_count = 5'd0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check($sformatf("vec%0d_armed", i), state_o, 3'd1);
      ch_valid = 4'hF;
      ch_valid[vecs[i].ch] = vecs[i].vld;
      for (int k = 0; k < 4; k++)
        ch_data[k*16 +: 16] = (k == int'(vecs[i].ch)) ? vecs[i].dat : ~vecs[i].dat;
      tick();
      ch_valid = '0;
      check($sformatf("vec%0d_triggered", i), triggered, vecs[i].exp_trig);
      check($sformatf("vec%0d_state", i), state_o, vecs[i].exp_trig ? 3'd3 : 3'd1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check($sformatf("vec%0d_abort_idle", i), state_o, 3'd0);
      check($sformatf("vec%0d_abort_rd_valid", i), rd_valid, 0);
    end

    // Trigger at stamp 5 with post_count 2; a repeat match in POST must not reload.
    mode = 1'b0; post_count = 5'd2; trig_ch = 2'd2; trig_value = 16'h00A5; trig_mask = 16'hFFFF;
    arm_at_zero();
    for (int s = 0; s < 8; s++) begin
      drive(s, 4'hF);
      if (s == 5 || s == 6) ch_data[2*16 +: 16] = 16'h00A5;
      exp_e[s] = {8'(s), 4'hF, ch_data};
      tick();
      if (s == 5) check("A_post_state", state_o, 3'd2);
    end
    ch_valid = '0;
    check("A_done_state", state_o, 3'd3);
    check("A_triggered", triggered, 1);
    check("A_entry_count", entry_count, 8);
    tick();
    check("A_read_state", state_o, 3'd4);
    drain(8, -1);

    // Trigger on the 20th sample with post_count 0: oldest surviving stamp is 4.
    mode = 1'b0; post_count = 5'd0; trig_ch = 2'd0; trig_value = 16'h0013; trig_mask = 16'hFFFF;
    arm_at_zero();
    arm = 1'b1;
    for (int s = 0; s < 20; s++) begin
      drive(s, 4'hF);
      if (s >= 4) exp_e[s-4] = {8'(s), 4'hF, ch_data};
      tick();
      if (s == 18) begin
        check("B_armed_s18", state_o, 3'd1);
        check("B_count_sat", entry_count, 16);
      end
    end
    arm = 1'b0; ch_valid = '0;
    check("B_done_state", state_o, 3'd3);
    check("B_triggered", triggered, 1);
    tick();
    drain(16, -1);

    // Fill mode with alternate qualified cycles; always-matching trigger is ignored.
    mode = 1'b1; post_count = 5'd0; trig_ch = 2'd0; trig_value = 16'h0000; trig_mask = 16'h0000;
    arm_at_zero();
    for (int s = 0; s < 31; s++) begin
      drive(s, (s % 2 == 0) ? 4'hF : 4'h0);
      if (s % 2 == 0) exp_e[s/2] = {8'(s), 4'hF, ch_data};
      tick();
      if (s == 28) check("C_armed_s28", state_o, 3'd1);
    end
    ch_valid = '0;
    check("C_done_state", state_o, 3'd3);
    check("C_entry_count", entry_count, 16);
    check("C_not_triggered", triggered, 0);
    tick();
    drain(16, 3);

    // abort together with arm in POST lands in IDLE; only a later arm re-arms.
    mode = 1'b0; post_count = 5'd5; trig_ch = 2'd0; trig_mask = 16'h0000;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    drive(0, 4'hF);
    tick();
    ch_valid = '0;
    check("D_post_state", state_o, 3'd2);
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    check("D_abort_idle", state_o, 3'd0);
    tick();
    check("D_stay_idle", state_o, 3'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("D_rearmed", state_o, 3'd1);
    check("D_rearm_count", entry_count, 0);
    check("D_rearm_trig", triggered, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // reset during READ.
    post_count = 5'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    drive(0, 4'hF);
    tick();
    ch_valid = '0;
    tick();
    check("E_read_valid", rd_valid, 1);
    check("E_read_count", entry_count, 1);
    reset = 1'b1;
    tick();
    check("E_rst_rd_valid", rd_valid, 0);
    check("E_rst_count", entry_count, 0);
    check("E_rst_state", state_o, 3'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
